// File: rtl/dff_pipe_en_if.sv
// Bus bundle for the enable-gated register pipeline.
// Handshake: valid-only, no back-pressure. The producer raises in_valid with d
// on an en edge and the word is taken unconditionally. The consumer must sample
// q whenever out_valid=1 on an en edge, because that word is dropped on the next
// en edge. out_valid=0 always comes with q=0.
interface dff_pipe_en_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             out_valid;
  logic [CNT_W-1:0] occupancy;

  modport master (
    output en, flush, in_valid, d,
    input  q, out_valid, occupancy
  );

  modport slave (
    input  en, flush, in_valid, d,
    output q, out_valid, occupancy
  );
endinterface

// File: rtl/dff_pipe_en.sv
// Stallable WIDTH x DEPTH delay line. Each stage carries a valid bit. A single
// enable shifts every stage together, and a synchronous flush empties the line.
// The occupancy counter tracks how many stages hold a valid word.
module dff_pipe_en #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  dff_pipe_en_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] data [DEPTH];
  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] occ_next;

  // Occupancy after an en edge. Simultaneous entry and exit leaves the count
  // unchanged. Because the count equals the popcount of v, it cannot pass
  // DEPTH or drop below zero.
  always_comb begin
    occ_next = occ;
    if (bus.in_valid && !v[DEPTH-1]) begin
      occ_next = occ + CNT_ONE;
    end else if (!bus.in_valid && v[DEPTH-1]) begin
      occ_next = occ - CNT_ONE;
    end
  end

  // Stage registers and occupancy. Priority is reset, then flush, then en, then hold.
  // Bubbles carry zero data, so q is 0 whenever out_valid is 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v   <= '0;
      occ <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data[k] <= '0;
      end
    end else if (bus.flush) begin
      v   <= '0;
      occ <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data[k] <= '0;
      end
    end else if (bus.en) begin
      v[0]    <= bus.in_valid;
      data[0] <= bus.in_valid ? bus.d : '0;
      for (int k = 1; k < DEPTH; k++) begin
        v[k]    <= v[k-1];
        data[k] <= data[k-1];
      end
      occ <= occ_next;
    end
  end

  assign bus.q         = data[DEPTH-1];
  assign bus.out_valid = v[DEPTH-1];
  assign bus.occupancy = occ;
endmodule

// File: tb/tb_dff_pipe_en.sv
// Directed bench for dff_pipe_en at DEPTH=4, plus a random sweep of DEPTH=1 and
// DEPTH=7 copies checked against a slot-queue model.
module tb_dff_pipe_en;
  typedef logic [8:0] slot_t;

  logic clk;
  logic reset_n;

  dff_pipe_en_if #(.WIDTH(8), .DEPTH(4)) if4 ();
  dff_pipe_en_if #(.WIDTH(8), .DEPTH(1)) if1 ();
  dff_pipe_en_if #(.WIDTH(8), .DEPTH(7)) if7 ();

  dff_pipe_en #(.WIDTH(8), .DEPTH(4)) u4 (.clk(clk), .reset_n(reset_n), .bus(if4));
  dff_pipe_en #(.WIDTH(8), .DEPTH(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  dff_pipe_en #(.WIDTH(8), .DEPTH(7)) u7 (.clk(clk), .reset_n(reset_n), .bus(if7));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag,
                      input logic [31:0] oq, input logic [31:0] ov, input logic [31:0] oo,
                      input logic [31:0] eq, input logic [31:0] ev, input logic [31:0] eo);
    chk({tag, ".q"}, oq, eq);
    chk({tag, ".out_valid"}, ov, ev);
    chk({tag, ".occupancy"}, oo, eo);
  endtask

  // one rising edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic en, input logic flush, input logic iv, input logic [7:0] d);
    if4.en = en;
    if4.flush = flush;
    if4.in_valid = iv;
    if4.d = d;
  endtask

  // scoreboard: slot queues, index 0 is the last stage
  slot_t exp_q1[$];
  slot_t exp_q7[$];

  function automatic int count_valid(input slot_t s[$]);
    int c = 0;
    foreach (s[i]) if (s[i][8]) c++;
    return c;
  endfunction

  initial begin
    logic [7:0] ov_pat;
    logic [7:0] q_pat;
    int         occ_tab[8];
    int         e;
    int         eq;
    int         eo;
    slot_t      nw;
    slot_t      tmp;
    logic       r_en;
    logic       r_fl;
    logic       r_iv;
    logic [7:0] r_d;

    reset_n = 1'b0;
    drive4(1'b0, 1'b0, 1'b0, 8'h00);
    if1.en = 1'b0; if1.flush = 1'b0; if1.in_valid = 1'b0; if1.d = 8'h00;
    if7.en = 1'b0; if7.flush = 1'b0; if7.in_valid = 1'b0; if7.d = 8'h00;
    #12;
    chk3("reset_init4", if4.q, if4.out_valid, if4.occupancy, 0, 0, 0);
    chk3("reset_init1", if1.q, if1.out_valid, if1.occupancy, 0, 0, 0);
    chk3("reset_init7", if7.q, if7.out_valid, if7.occupancy, 0, 0, 0);

    // fill with FF, then reset asynchronously between edges
    reset_n = 1'b1;
    drive4(1'b1, 1'b0, 1'b1, 8'hFF);
    repeat (4) step();
    chk3("prefill", if4.q, if4.out_valid, if4.occupancy, 8'hFF, 1, 4);
    #3;
    reset_n = 1'b0;
    #1;
    chk3("async_reset", if4.q, if4.out_valid, if4.occupancy, 0, 0, 0);
    step();
    chk3("reset_held", if4.q, if4.out_valid, if4.occupancy, 0, 0, 0);
    reset_n = 1'b1;
    drive4(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    chk3("reset_release", if4.q, if4.out_valid, if4.occupancy, 0, 0, 0);

    // streaming 11..55 then drain
    for (int i = 0; i < 9; i++) begin
      if (i < 5) drive4(1'b1, 1'b0, 1'b1, 8'(8'h11 * (i + 1)));
      else       drive4(1'b1, 1'b0, 1'b0, 8'h00);
      step();
      e  = i + 1;
      eq = (e >= 4 && e <= 8) ? 8'h11 * (e - 3) : 0;
      eo = (e < 4) ? e : ((9 - e < 4) ? 9 - e : 4);
      chk3($sformatf("stream_e%0d", e), if4.q, if4.out_valid, if4.occupancy,
           eq, (eq != 0) ? 1 : 0, eo);
    end

    // stall: fill A1..A4, freeze 5 edges with random d, then drain
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, 1'b0, 1'b1, 8'(8'hA1 + i));
      step();
    end
    chk3("stall_fill", if4.q, if4.out_valid, if4.occupancy, 8'hA1, 1, 4);
    for (int i = 0; i < 5; i++) begin
      drive4(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      if (i == 2) begin
        #2 if4.en = 1'b1;
        #2 if4.en = 1'b0;
      end
      step();
      chk3($sformatf("stall_hold%0d", i), if4.q, if4.out_valid, if4.occupancy, 8'hA1, 1, 4);
    end
    for (int i = 1; i < 4; i++) begin
      drive4(1'b1, 1'b0, 1'b0, 8'h00);
      step();
      chk3($sformatf("stall_drain%0d", i), if4.q, if4.out_valid, if4.occupancy,
           8'hA1 + i, 1, 4 - i);
    end
    drive4(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    chk3("stall_empty", if4.q, if4.out_valid, if4.occupancy, 0, 0, 0);

    // bubbles: in_valid 1,0,1,0 with d=5A
    ov_pat  = 8'b0010_1000;
    q_pat   = 8'h5A;
    occ_tab = '{1, 1, 2, 2, 1, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      drive4(1'b1, 1'b0, (i < 4) ? ~i[0] : 1'b0, 8'h5A);
      step();
      chk3($sformatf("bubble_e%0d", i + 1), if4.q, if4.out_valid, if4.occupancy,
           ov_pat[i] ? q_pat : 8'h00, ov_pat[i], occ_tab[i]);
    end

    // flush with en: EE must never appear
    for (int i = 0; i < 3; i++) begin
      drive4(1'b1, 1'b0, 1'b1, 8'(8'hB1 + i));
      step();
    end
    chk3("flush_pre", if4.q, if4.out_valid, if4.occupancy, 0, 0, 3);
    drive4(1'b1, 1'b1, 1'b1, 8'hEE);
    step();
    chk3("flush_edge", if4.q, if4.out_valid, if4.occupancy, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, 1'b0, 1'b0, 8'h00);
      step();
      chk3($sformatf("flush_after%0d", i), if4.q, if4.out_valid, if4.occupancy, 0, 0, 0);
    end

    // flush pulse between edges is ignored
    drive4(1'b1, 1'b0, 1'b1, 8'hC1);
    step();
    drive4(1'b0, 1'b0, 1'b0, 8'h00);
    #2 if4.flush = 1'b1;
    #2 if4.flush = 1'b0;
    step();
    chk3("flush_pulse", if4.q, if4.out_valid, if4.occupancy, 0, 0, 1);
    drive4(1'b0, 1'b1, 1'b0, 8'h00);
    step();
    chk3("flush_no_en", if4.q, if4.out_valid, if4.occupancy, 0, 0, 0);
    drive4(1'b0, 1'b0, 1'b0, 8'h00);

    // random sweep, DEPTH=1 and DEPTH=7 share the stimulus
    exp_q1 = {};
    exp_q7 = {};
    repeat (1) exp_q1.push_back(9'h000);
    repeat (7) exp_q7.push_back(9'h000);
    for (int c = 0; c < 200; c++) begin
      r_en = ($urandom_range(0, 3) != 0);
      r_fl = ($urandom_range(0, 15) == 0);
      r_iv = 1'($urandom_range(0, 1));
      r_d  = 8'($urandom_range(0, 255));
      if1.en = r_en; if1.flush = r_fl; if1.in_valid = r_iv; if1.d = r_d;
      if7.en = r_en; if7.flush = r_fl; if7.in_valid = r_iv; if7.d = r_d;
      step();
      nw = {r_iv, r_iv ? r_d : 8'h00};
      if (r_fl) begin
        foreach (exp_q1[i]) exp_q1[i] = 9'h000;
        foreach (exp_q7[i]) exp_q7[i] = 9'h000;
      end else if (r_en) begin
        exp_q1.push_back(nw);
        tmp = exp_q1.pop_front();
        exp_q7.push_back(nw);
        tmp = exp_q7.pop_front();
      end
      chk3($sformatf("rand1_c%0d", c), if1.q, if1.out_valid, if1.occupancy,
           exp_q1[0][7:0], exp_q1[0][8], count_valid(exp_q1));
      chk3($sformatf("rand7_c%0d", c), if7.q, if7.out_valid, if7.occupancy,
           exp_q7[0][7:0], exp_q7[0][8], count_valid(exp_q7));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dff_pipe_en.md
# dff_pipe_en

Parametrised, enable-gated register pipeline: a WIDTH-bit datapath delayed by DEPTH register stages, each carrying a valid bit. A single enable advances all stages together, a synchronous flush drops everything in flight, and an occupancy counter reports how many valid words are currently held. This is the multi-stage, multi-bit successor to the single-bit enable flip-flop, used as a stallable delay line between sequential blocks.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; not overridden)

- clk  input  1  rising-edge clock (the only clock)
- reset_n  input  1  asynchronous active-low reset
- en  input  1  advance enable; 0 = every stage holds
- flush  input  1  synchronous clear of all valid bits
- in_valid  input  1  d carries a valid word this cycle
- d  input  WIDTH  input data
- q  output  WIDTH  data of last stage (registered)
- out_valid  output  1  valid bit of last stage (registered)
- occupancy  output  CNT_W  number of stages holding a valid word (registered)

## Operation
- Storage: stage[0..DEPTH-1], each with {v, data}. stage[DEPTH-1] drives out_valid/q directly; no combinational path from any input to any output.
- Priority per rising edge: reset_n low > flush > en > hold.
- flush=1: all v cleared, all data set to 0, occupancy=0. Takes priority over en; the word on d that cycle is dropped.
- en=1, flush=0: stage[0] <= {in_valid, in_valid ? d : 0}; stage[k] <= stage[k-1] for k=1..DEPTH-1. Bubbles always carry zero data, so q=0 whenever out_valid=0.
- en=0, flush=0: every stage, and occupancy, hold; d and in_valid are ignored.
- Occupancy on an en edge: occupancy + in_valid − v(stage[DEPTH-1]) before the edge. The simultaneous entry and exit case leaves the count unchanged. The count must equal the popcount of the valid bits at all times, stays within 0..DEPTH, and never wraps.
- The word leaving stage[DEPTH-1] on an en edge is lost. There is no back-pressure; the consumer samples q when out_valid=1.
- DEPTH=1: the pipeline degenerates to one enable flip-flop with a valid bit. It is functionally identical to the single-bit enable DFF when WIDTH=1 and in_valid=1.

## Timing
- Reset: when reset_n falls, without waiting for clk, every v=0, every data=0, q=0, out_valid=0, occupancy=0. These values hold while reset_n is low. The first capture happens at the first rising edge after reset_n rises.
- Reset mid-operation: all in-flight words are discarded. The pipeline does not retain or replay them.
- Latency: a word presented with in_valid=1 at an en edge N appears on q/out_valid after the DEPTH-th en edge counted from N inclusive. Edges with en=0 in between add cycles but lose nothing.
- Throughput: one word per en edge.
- Outputs change only on a rising clk edge or on an asynchronous reset assertion.
- flush and en are sampled only at clk edges. A pulse on either between edges has no effect.

## Test plan
- Reset: drive d=8'hFF, in_valid=1, en=1, then assert reset_n=0 between edges. Required: q=0, out_valid=0, occupancy=0 immediately, and they remain 0 until after reset_n releases.
- Streaming, DEPTH=4: en=1, push 8'h11, 8'h22, 8'h33, 8'h44, 8'h55 on consecutive edges. Required: 8'h11 appears with out_valid=1 after the 4th edge, then one word per edge in order. occupancy reads 1,2,3,4,4.
- Stall: fill with 8'hA1..8'hA4, then hold en=0 for 5 edges while d toggles randomly, then set en=1. Required: q, out_valid and occupancy are frozen during the stall, and 8'hA1..8'hA4 emerge intact in order.
- Bubbles: en=1 with in_valid pattern 1,0,1,0 and d=8'h5A every cycle. Required: out_valid pattern 1,0,1,0 after the latency, q=0 on the invalid slots, occupancy never exceeds 2.
- Flush with en: with 3 valid words in flight, assert flush=1 and en=1 with in_valid=1, d=8'hEE. Required: after the edge, occupancy=0 and out_valid=0. 8'hEE never appears on q.
- Randomised sweep at DEPTH=1 and DEPTH=7 against a queue model. Required: q/out_valid match the model every cycle, and occupancy equals the model length.
